dma_mem_responder: RTL and testbench

- Word-organised memory target that answers the DMA controller's memory bus (addr/data/mem_read/mem_write/mem_ready).
- Acts as the responder end of that bus: captures each read or write strobe, inserts a programmable number of wait states, then holds mem_ready until the initiator completes the handshake.
- Used as the system scratch RAM and as the standard bus model in DMA benches.
- A side-band backdoor port allows preload and inspection of memory contents.

---
 rtl/dma_bus_pkg.sv | 22 ++
 rtl/dma_mem_array.sv | 38 +++
 rtl/dma_mem_responder.sv | 141 ++++++++++++++
 tb/tb_dma_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_bus_pkg.sv
// Shared definitions for the DMA memory bus: responder state encoding,
// default error read data and the target address-decode helper.
package dma_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

   // True when addr is word aligned and lies in [base, base+span).
   function automatic logic addr_ok(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] span);
      logic [31:0] off;
      off = addr - base;
      return (addr >= base) && (off < span) && (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/dma_mem_array.sv
// DEPTH x 32 storage: bus write port (wins over backdoor on the same word),
// backdoor write, registered bus read and combinational backdoor read.
module dma_mem_array #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_bus_we,
   input  logic [AW-1:0] i_bus_waddr,
   input  logic [31:0]   i_bus_wdata,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [31:0]   o_rd_data,
   input  logic          i_dbg_we,
   input  logic [AW-1:0] i_dbg_addr,
   input  logic [31:0]   i_dbg_wdata,
   output logic [31:0]   o_dbg_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rd_data;

   // Bus write is issued last so it overrides a backdoor write to the same index.
   always_ff @(posedge clk) begin
      if (i_dbg_we) r_mem[i_dbg_addr] <= i_dbg_wdata;
      if (i_bus_we) r_mem[i_bus_waddr] <= i_bus_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data   = r_rd_data;
   assign o_dbg_rdata = r_mem[i_dbg_addr];

endmodule

// File: rtl/dma_mem_responder.sv
// Word-organised memory target for the DMA bus: captures a request, inserts
// WAIT_STATES wait cycles, then holds mem_ready until the initiator's strobe.
module dma_mem_responder
   import dma_bus_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [31:0]                mem_addr,
   input  logic [31:0]                mem_wdata,
   input  logic                       mem_read,
   input  logic                       mem_write,
   output logic [31:0]                mem_rdata,
   output logic                       mem_ready,
   output logic                       mem_err,
   input  logic [$clog2(DEPTH)-1:0]   dbg_addr,
   input  logic                       dbg_we,
   input  logic [31:0]                dbg_wdata,
   output logic [31:0]                dbg_rdata
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [3:0]  WS = 4'(WAIT_STATES);

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_idx;
   logic [31:0]   r_wdata;
   logic          r_op_wr;
   logic          r_err;
   logic          r_ready;
   logic          r_mem_err;
   logic          r_rd_err;

   logic          w_strobe;
   logic          w_err;
   logic [AW-1:0] w_idx;
   logic          w_done;
   logic          w_bus_we;
   logic          w_rd_en;
   logic [AW-1:0] w_rd_addr;
   logic          w_rd_err;
   logic [31:0]   w_rd_data;

   assign w_strobe = mem_read | mem_write;
   assign w_err    = !addr_ok(mem_addr, BASE_ADDR, 32'(DEPTH * 4)) || (mem_read && mem_write);
   assign w_idx    = mem_addr[AW+1:2] - BASE_ADDR[AW+1:2];
   assign w_done   = (r_state == RESP) && (r_op_wr ? mem_write : mem_read);
   assign w_bus_we = w_done && r_op_wr && !r_err;

   // Array read is issued on every edge that lands (or stays) in RESP for a read,
   // so the registered read data is valid throughout the ready window.
   always_comb begin
      w_rd_en   = 1'b0;
      w_rd_addr = r_idx;
      w_rd_err  = r_err;
      case (r_state)
         IDLE: if (mem_read && !mem_write && WAIT_STATES == 0) begin
            w_rd_en   = 1'b1;
            w_rd_addr = w_idx;
            w_rd_err  = w_err;
         end
         WAIT: if (r_cnt == 4'd1 && !r_op_wr) w_rd_en = 1'b1;
         RESP: if (!w_done && !r_op_wr)       w_rd_en = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_wdata   <= '0;
         r_op_wr   <= 1'b0;
         r_err     <= 1'b0;
         r_ready   <= 1'b0;
         r_mem_err <= 1'b0;
         r_rd_err  <= 1'b0;
      end else begin
         if (w_rd_en) r_rd_err <= w_rd_err;
         case (r_state)
            IDLE: if (w_strobe) begin
               r_idx   <= w_idx;
               r_wdata <= mem_wdata;
               r_op_wr <= mem_write;
               r_err   <= w_err;
               if (WAIT_STATES == 0) begin
                  r_state   <= RESP;
                  r_ready   <= 1'b1;
                  r_mem_err <= w_err;
               end else begin
                  r_cnt   <= WS;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state   <= RESP;
                  r_ready   <= 1'b1;
                  r_mem_err <= r_err;
               end
            end
            RESP: if (w_done) begin
               r_state   <= IDLE;
               r_ready   <= 1'b0;
               r_mem_err <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   dma_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk         (clk),
      .reset       (reset),
      .i_bus_we    (w_bus_we),
      .i_bus_waddr (r_idx),
      .i_bus_wdata (r_wdata),
      .i_rd_en     (w_rd_en),
      .i_rd_addr   (w_rd_addr),
      .o_rd_data   (w_rd_data),
      .i_dbg_we    (dbg_we),
      .i_dbg_addr  (dbg_addr),
      .i_dbg_wdata (dbg_wdata),
      .o_dbg_rdata (dbg_rdata)
   );

   assign mem_ready = r_ready;
   assign mem_err   = r_mem_err;
   assign mem_rdata = r_rd_err ? ERR_RDATA : w_rd_data;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Bench for dma_mem_responder: a WAIT_STATES=2 and a WAIT_STATES=0 instance
// share one bus master; read results are checked through a scoreboard queue.
module tb_dma_mem_responder;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m_addr, m_wdata;
   logic        m_read, m_write;
   logic        use0;
   logic [7:0]  dbg_addr;
   logic        dbg_we;
   logic [31:0] dbg_wdata;

   logic [31:0] rdata2, rdata0, drd2, drd0;
   logic        ready2, ready0, err2, err0;
   logic [31:0] b_rdata, b_drd;
   logic        b_ready, b_err;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   dma_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(2)) dut (
      .clk(clk), .reset(reset),
      .mem_addr(m_addr), .mem_wdata(m_wdata),
      .mem_read(m_read & ~use0), .mem_write(m_write & ~use0),
      .mem_rdata(rdata2), .mem_ready(ready2), .mem_err(err2),
      .dbg_addr(dbg_addr), .dbg_we(dbg_we & ~use0), .dbg_wdata(dbg_wdata), .dbg_rdata(drd2)
   );

   dma_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset),
      .mem_addr(m_addr), .mem_wdata(m_wdata),
      .mem_read(m_read & use0), .mem_write(m_write & use0),
      .mem_rdata(rdata0), .mem_ready(ready0), .mem_err(err0),
      .dbg_addr(dbg_addr), .dbg_we(dbg_we & use0), .dbg_wdata(dbg_wdata), .dbg_rdata(drd0)
   );

   assign b_rdata = use0 ? rdata0 : rdata2;
   assign b_ready = use0 ? ready0 : ready2;
   assign b_err   = use0 ? err0   : err2;
   assign b_drd   = use0 ? drd0   : drd2;

   task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      dbg_addr = a; dbg_wdata = d; dbg_we = 1'b1;
      @(negedge clk);
      dbg_we = 1'b0;
   endtask

   task automatic bd_read(input logic [7:0] a, output logic [31:0] d);
      dbg_addr = a;
      #1;
      d = b_drd;
   endtask

   // One bus transfer. lat = edges from capture until mem_ready seen,
   // edges = lat plus the edges up to completion; ok = clean handshake.
   task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit pulse, input bit tail,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int edges, output bit ok);
      bit s, hi, done;
      int n;
      ok = 1'b1; lat = 0; edges = 0; rdata = 'x; err = 'x; s = 1'b1; done = 1'b0;
      @(negedge clk);
      m_addr = addr; m_wdata = wdata; m_read = rd; m_write = wr;
      n = 0;
      while (!b_ready && n < 40) begin
         @(posedge clk); #1;
         lat++; n++;
         if (pulse) begin s = ~s; m_read = rd & s; m_write = wr & s; end
      end
      edges = lat;
      if (!b_ready) begin
         ok = 1'b0; m_read = 1'b0; m_write = 1'b0;
         return;
      end
      rdata = b_rdata;
      err   = b_err;
      n = 0;
      while (!done && n < 10) begin
         hi = s;
         @(posedge clk); #1;
         edges++; n++;
         if (hi) begin
            if (b_ready) ok = 1'b0;
            done = 1'b1;
         end else begin
            if (!b_ready) ok = 1'b0;
            if (pulse) begin s = ~s; m_read = rd & s; m_write = wr & s; end
         end
      end
      if (!done) ok = 1'b0;
      m_read = 1'b0; m_write = 1'b0;
      if (tail) repeat (3) begin
         @(posedge clk); #1;
         if (b_ready) ok = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL reset_ready2: got %b want 0", ready2); end
      checks++; if (err2 !== 1'b0)   begin errors++; $display("FAIL reset_err2: got %b want 0", err2); end
      checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata2: got %h want 0", rdata2); end
      checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", ready0); end
      checks++; if (err0 !== 1'b0)   begin errors++; $display("FAIL reset_err0: got %b want 0", err0); end
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h want 0", rdata0); end
      reset = 1'b0;
   endtask

   task automatic test_read_held;
      logic [31:0] rd; logic er; int lat, edges; bit ok; exp_t e;
      use0 = 1'b0;
      bd_write(8'd0, 32'h1234_5678);
      sb.push_back('{data: 32'h1234_5678, err: 1'b0});
      xfer(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b1, rd, er, lat, edges, ok);
      e = sb.pop_front();
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL read_held_handshake: got %b want 1", ok); end
      checks++; if (lat != 3)    begin errors++; $display("FAIL read_held_latency: got %0d want 3", lat); end
      checks++; if (edges != 4)  begin errors++; $display("FAIL read_held_edges: got %0d want 4", edges); end
      checks++; if (rd !== e.data) begin errors++; $display("FAIL read_held_rdata: got %h want %h", rd, e.data); end
      checks++; if (er !== e.err)  begin errors++; $display("FAIL read_held_err: got %b want %b", er, e.err); end
   endtask

   task automatic test_write_pulse;
      logic [31:0] rd, d; logic er; int lat, edges; bit ok;
      use0 = 1'b0;
      xfer(1'b0, 1'b1, 32'h0000_1008, 32'hCAFE_0001, 1'b1, 1'b1, rd, er, lat, edges, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL write_pulse_handshake: got %b want 1", ok); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL write_pulse_err: got %b want 0", er); end
      checks++; if (edges != 5)  begin errors++; $display("FAIL write_pulse_edges: got %0d want 5", edges); end
      bd_read(8'd2, d);
      checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL write_pulse_mem2: got %h want cafe0001", d); end
   endtask

   task automatic test_errors;
      logic [31:0] addrs [4];
      logic        errs  [4];
      logic [31:0] rd, d; logic er; int lat, edges; bit ok; exp_t e;
      use0 = 1'b0;
      addrs = '{32'h0000_0FFC, 32'h0000_1002, 32'h0000_1400, 32'h0000_13FC};
      errs  = '{1'b1, 1'b1, 1'b1, 1'b0};
      bd_write(8'd255, 32'h0BAD_F00D);
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{data: errs[i] ? 32'hDEAD_BEEF : 32'h0BAD_F00D, err: errs[i]});
         xfer(1'b1, 1'b0, addrs[i], 32'h0, 1'b0, 1'b0, rd, er, lat, edges, ok);
         e = sb.pop_front();
         checks++; if (ok !== 1'b1)   begin errors++; $display("FAIL err_read_handshake[%0d]: got %b want 1", i, ok); end
         checks++; if (er !== e.err)  begin errors++; $display("FAIL err_read_err[%0d]: got %b want %b", i, er, e.err); end
         checks++; if (rd !== e.data) begin errors++; $display("FAIL err_read_rdata[%0d]: got %h want %h", i, rd, e.data); end
      end
      // Out-of-range write whose truncated index aliases word 0.
      xfer(1'b0, 1'b1, 32'h0000_1400, 32'hFFFF_FFFF, 1'b0, 1'b1, rd, er, lat, edges, ok);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_write_err: got %b want 1", er); end
      bd_read(8'd0, d);
      checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL err_write_mem0: got %h want 12345678", d); end
   endtask

   task automatic test_both_strobes;
      logic [31:0] rd, d; logic er; int lat, edges; bit ok;
      use0 = 1'b0;
      bd_write(8'd1, 32'h1111_1111);
      xfer(1'b1, 1'b1, 32'h0000_1004, 32'hBAD0_BAD0, 1'b0, 1'b1, rd, er, lat, edges, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL both_handshake: got %b want 1", ok); end
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL both_err: got %b want 1", er); end
      bd_read(8'd1, d);
      checks++; if (d !== 32'h1111_1111) begin errors++; $display("FAIL both_mem1: got %h want 11111111", d); end
   endtask

   task automatic test_reset_abort;
      logic [31:0] rd, d; logic er; int lat, edges, n; bit ok, seen; exp_t e;
      use0 = 1'b0;
      bd_write(8'd4, 32'h5555_AAAA);
      @(negedge clk);
      m_addr = 32'h0000_1010; m_wdata = 32'hFFFF_0000; m_write = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL abort_wait_ready: got %b want 0", b_ready); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      m_write = 1'b0; reset = 1'b0;
      seen = 1'b0;
      repeat (6) begin @(posedge clk); #1; if (b_ready) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_response: got %b want 0", seen); end
      bd_read(8'd4, d);
      checks++; if (d !== 32'h5555_AAAA) begin errors++; $display("FAIL abort_mem4: got %h want 5555aaaa", d); end
      // Reset during the ready window of a read.
      @(negedge clk);
      m_addr = 32'h0000_1000; m_read = 1'b1;
      n = 0;
      while (!b_ready && n < 20) begin @(posedge clk); #1; n++; end
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL abort_resp_reached: got %b want 1", b_ready); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL abort_resp_ready: got %b want 0", b_ready); end
      checks++; if (b_rdata !== 32'h0) begin errors++; $display("FAIL abort_resp_rdata: got %h want 0", b_rdata); end
      @(negedge clk);
      m_read = 1'b0; reset = 1'b0;
      sb.push_back('{data: 32'h1234_5678, err: 1'b0});
      xfer(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b1, rd, er, lat, edges, ok);
      e = sb.pop_front();
      checks++; if (ok !== 1'b1 || lat != 3) begin errors++; $display("FAIL post_reset_read: ok %b lat %0d want ok 1 lat 3", ok, lat); end
      checks++; if (rd !== e.data) begin errors++; $display("FAIL post_reset_rdata: got %h want %h", rd, e.data); end
   endtask

   task automatic test_ws0_back_to_back;
      logic [31:0] rd, d; logic er; int lat, edges; bit ok; exp_t e;
      use0 = 1'b1;
      bd_write(8'd0, 32'hA5A5_0000);
      sb.push_back('{data: 32'hA5A5_0000, err: 1'b0});
      xfer(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0, rd, er, lat, edges, ok);
      e = sb.pop_front();
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ws0_read_handshake: got %b want 1", ok); end
      checks++; if (lat != 1 || edges != 2) begin errors++; $display("FAIL ws0_read_timing: lat %0d edges %0d want 1 2", lat, edges); end
      checks++; if (rd !== e.data || er !== e.err) begin errors++; $display("FAIL ws0_read_data: got %h/%b want %h/%b", rd, er, e.data, e.err); end
      xfer(1'b0, 1'b1, 32'h0000_1004, 32'hC0DE_0004, 1'b0, 1'b1, rd, er, lat, edges, ok);
      checks++; if (ok !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL ws0_write_handshake: ok %b err %b want 1 0", ok, er); end
      checks++; if (lat != 1 || edges != 2) begin errors++; $display("FAIL ws0_write_timing: lat %0d edges %0d want 1 2", lat, edges); end
      bd_read(8'd1, d);
      checks++; if (d !== 32'hC0DE_0004) begin errors++; $display("FAIL ws0_write_mem1: got %h want c0de0004", d); end
      use0 = 1'b0;
   endtask

   task automatic test_dma_copy;
      logic [31:0] src [4];
      logic [31:0] rd, d; logic er; int lat, edges; bit ok; exp_t e;
      use0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         src[i] = 32'h0F00_0000 + $urandom_range(0, 32'h00FF_FFFF);
         bd_write(8'(i), src[i]);
      end
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{data: src[i], err: 1'b0});
         xfer(1'b1, 1'b0, 32'h0000_1000 + 32'(4 * i), 32'h0, 1'b0, 1'b0, rd, er, lat, edges, ok);
         e = sb.pop_front();
         checks++; if (ok !== 1'b1 || rd !== e.data || er !== e.err) begin
            errors++; $display("FAIL dma_read[%0d]: got %h/%b ok %b want %h/%b", i, rd, er, ok, e.data, e.err);
         end
         xfer(1'b0, 1'b1, 32'h0000_1080 + 32'(4 * i), rd, 1'b0, 1'b0, rd, er, lat, edges, ok);
      end
      for (int i = 0; i < 4; i++) begin
         bd_read(8'(32 + i), d);
         checks++; if (d !== src[i]) begin errors++; $display("FAIL dma_dest[%0d]: got %h want %h", 32 + i, d, src[i]); end
      end
   endtask

   initial begin
      m_addr = '0; m_wdata = '0; m_read = 1'b0; m_write = 1'b0; use0 = 1'b0;
      dbg_addr = '0; dbg_we = 1'b0; dbg_wdata = '0;
      test_reset();
      test_read_held();
      test_write_pulse();
      test_errors();
      test_both_strobes();
      test_reset_abort();
      test_ws0_back_to_back();
      test_dma_copy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
